// File: rtl/digit_sub_seq_pkg.sv
// Shared types and constants for the digit-serial subtraction controller.
// Included by the cell, the interface users and the top-level sequencer.
package digit_sub_pkg;

    localparam int DIGIT_W = 4;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // FIX is always encoded so the state width does not depend on the build option.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/digit_sub_seq_if.sv
// Request/response bundle between a requesting unit (master) and the
// digit-serial subtractor (slave).
interface digit_sub_seq_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  mode;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  neg;
    logic                  invalid;

    modport master (
        output start, mode, a, b,
        input  ready, busy, done, result, neg, invalid
    );

    modport slave (
        input  start, mode, a, b,
        output ready, busy, done, result, neg, invalid
    );

endinterface

// File: rtl/digit_sub_cell.sv
// Combinational complement-and-add digit cell: a_d + comp(b_d) + cin, where
// comp is 9's complement in decimal mode and 1's complement in binary mode.
module digit_sub_cell
    import digit_sub_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               cin,
    input  logic               mode,
    output logic [DIGIT_W-1:0] d,
    output logic               cout
);

    logic [DIGIT_W-1:0] comp;
    logic [DIGIT_W:0]   sum;

    // Out-of-range BCD inputs wrap harmlessly; the result is undefined then anyway.
    always_comb begin
        comp = (mode == MODE_DEC) ? (BCD_MAX - b_d) : ~b_d;
        sum  = {1'b0, a_d} + {1'b0, comp} + {{DIGIT_W{1'b0}}, cin};
        d    = sum[DIGIT_W-1:0];
        cout = sum[DIGIT_W];
        if (mode == MODE_DEC) begin
            if (sum >= 5'd10) begin
                d    = DIGIT_W'(sum - 5'd10);
                cout = 1'b1;
            end else begin
                cout = 1'b0;
            end
        end
    end

endmodule

// File: rtl/digit_sub_seq.sv
// Digit-serial A - B sequencer, one digit per clock, LSB first.
// Build option DIGIT_SUB_RECOMP_EN adds the FIX pass that returns negative results as magnitudes.
module digit_sub_seq
    import digit_sub_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    digit_sub_seq_if.slave bus
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             neg_q, neg_d;
    logic             invalid_q, invalid_d;

    logic [DIGIT_W-1:0] cell_a, cell_b, cell_d;
    logic               cell_cout;
    logic               bad_bcd;

    // In FIX the cell computes 0 - result_digit, re-using the same complement path.
    always_comb begin
        cell_a = a_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        cell_b = b_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        if (state_q == FIX) begin
            cell_a = '0;
            cell_b = result_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        end
    end

    digit_sub_cell u_cell (
        .a_d  (cell_a),
        .b_d  (cell_b),
        .cin  (carry_q),
        .mode (mode_q),
        .d    (cell_d),
        .cout (cell_cout)
    );

    always_comb begin
        bad_bcd = 1'b0;
        for (int i = 0; i < 2*DIGITS; i++) begin
            if (i < DIGITS) begin
                if (bus.a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) bad_bcd = 1'b1;
            end else begin
                if (bus.b[(i-DIGITS)*DIGIT_W +: DIGIT_W] > BCD_MAX) bad_bcd = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        neg_d     = neg_q;
        invalid_d = invalid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    mode_d    = bus.mode;
                    carry_d   = 1'b1;
                    idx_d     = '0;
                    neg_d     = 1'b0;
                    invalid_d = (bus.mode == MODE_DEC) && bad_bcd;
                    state_d   = SUB;
                end
            end
            SUB: begin
                result_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = cell_d;
                carry_d = cell_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    neg_d   = ~cell_cout;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef DIGIT_SUB_RECOMP_EN
                    if (!cell_cout) begin
                        carry_d = 1'b1;
                        state_d = FIX;
                    end
`endif
                end
            end
            FIX: begin
                result_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = cell_d;
                carry_d = cell_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            mode_q    <= MODE_BIN;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == SUB) || (state_q == FIX);
    assign bus.done    = (state_q == DONE);
    assign bus.result  = result_q;
    assign bus.neg     = neg_q;
    assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_digit_sub_seq.sv
// Scoreboard bench for digit_sub_seq (DIGITS=4), directed vectors.
// Expectations follow DIGIT_SUB_RECOMP_EN when it is defined for the build.
module tb_digit_sub_seq;

    localparam int DIGITS = 4;

`ifdef DIGIT_SUB_RECOMP_EN
    localparam int          NEG_LAT    = 2*DIGITS + 1;
    localparam logic [15:0] DEC_NEG_R  = 16'h0025;
    localparam logic [15:0] BIN_NEG_R  = 16'h0004;
`else
    localparam int          NEG_LAT    = DIGITS + 1;
    localparam logic [15:0] DEC_NEG_R  = 16'h9975;
    localparam logic [15:0] BIN_NEG_R  = 16'hFFFC;
`endif
    localparam int POS_LAT = DIGITS + 1;

    typedef struct {
        int          id;
        logic [15:0] result;
        logic        neg;
        logic        invalid;
        logic        chk_result;
        int          latency;
        int          accept;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle_cnt;
    int   compared;
    int   mismatched;
    exp_t exp_q[$];

    digit_sub_seq_if #(.DIGITS(DIGITS)) bus ();

    digit_sub_seq #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int id, input logic m, input logic [15:0] av,
                                 input logic [15:0] bv, input logic [15:0] er,
                                 input logic en, input logic ei, input logic ec,
                                 input int lat, input bit push);
        exp_t e;
        bit   got_ready;
        got_ready = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got_ready = 1;
                break;
            end
        end
        if (!got_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ready_timeout op %0d: ready stayed 0, expected 1", id);
            return;
        end
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            e.id = id; e.result = er; e.neg = en; e.invalid = ei;
            e.chk_result = ec; e.latency = lat; e.accept = cycle_cnt;
            exp_q.push_back(e);
        end
    endtask

    // Latency counts cycle numbers after the accept edge, so DONE right after SUB is DIGITS+1.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected 0", cycle_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_result) checkOutput($sformatf("result op %0d", e.id), 32'(bus.result), 32'(e.result));
                    checkOutput($sformatf("neg op %0d", e.id), 32'(bus.neg), 32'(e.neg));
                    checkOutput($sformatf("invalid op %0d", e.id), 32'(bus.invalid), 32'(e.invalid));
                    checkOutput($sformatf("latency op %0d", e.id), 32'(cycle_cnt - e.accept + 1), 32'(e.latency));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ready",   32'(bus.ready),   32'd1);
        checkOutput("reset busy",    32'(bus.busy),    32'd0);
        checkOutput("reset done",    32'(bus.done),    32'd0);
        checkOutput("reset result",  32'(bus.result),  32'd0);
        checkOutput("reset neg",     32'(bus.neg),     32'd0);
        checkOutput("reset invalid", 32'(bus.invalid), 32'd0);
        rst = 1'b0;

        applyStimulus(1, 1'b1, 16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 1'b1, POS_LAT, 1);
        applyStimulus(2, 1'b1, 16'h0017, 16'h0042, DEC_NEG_R, 1'b1, 1'b0, 1'b1, NEG_LAT, 1);
        applyStimulus(3, 1'b0, 16'h0005, 16'h0009, BIN_NEG_R, 1'b1, 1'b0, 1'b1, NEG_LAT, 1);
        applyStimulus(4, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, POS_LAT, 1);
        applyStimulus(5, 1'b1, 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, POS_LAT, 1);

        // A start during SUB with different operands must not disturb the running operation.
        applyStimulus(6, 1'b1, 16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 1'b1, POS_LAT, 1);
        @(negedge clk);
        checkOutput("busy in sub",  32'(bus.busy),  32'd1);
        checkOutput("ready in sub", 32'(bus.ready), 32'd0);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 16'h9999;
        bus.b     = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;

        applyStimulus(7, 1'b0, 16'h00A0, 16'h0001, 16'h009F, 1'b0, 1'b0, 1'b1, POS_LAT, 1);

        // Aborted operation: nothing is queued, so any done pulse it produced is flagged.
        applyStimulus(8, 1'b1, 16'h0042, 16'h0017, 16'h0000, 1'b0, 1'b0, 1'b0, POS_LAT, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort ready",  32'(bus.ready),  32'd1);
        checkOutput("abort busy",   32'(bus.busy),   32'd0);
        checkOutput("abort result", 32'(bus.result), 32'd0);
        checkOutput("abort neg",    32'(bus.neg),    32'd0);
        repeat (12) @(negedge clk);

        applyStimulus(9, 1'b1, 16'h0999, 16'h0001, 16'h0998, 1'b0, 1'b0, 1'b1, POS_LAT, 1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/digit_sub_seq.md
# digit_sub_seq

Digit-serial subtraction controller that sequences a single 4-bit complement-and-add digit cell over a multi-digit operand word, one digit per clock, LSB first. It computes A − B as A + complement(B) + 1. The complement is 9's complement in decimal (BCD) mode and 1's complement in binary mode, so the result is the 10's or 2's complement difference. It sits between a requesting unit and the shared complement datapath: it owns the digit index, carry chain register, mode selection and the start/done handshake.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per operand (≥1).
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only on an edge where `ready`=1.
- `mode`  in  1: 1 = decimal (9's complement path), 0 = binary (1's complement path); sampled at accept.
- `a`  in  4*DIGITS: minuend, sampled at accept.
- `b`  in  4*DIGITS: subtrahend, sampled at accept.
- `ready`  out  1: high only in IDLE.
- `busy`  out  1: high in SUB and FIX.
- `done`  out  1: one-cycle pulse, high only in DONE.
- `result`  out  4*DIGITS: difference; held from DONE until next accept.
- `neg`  out  1: 1 when A < B (final carry-out = 0).
- `invalid`  out  1: decimal mode only; any digit of `a` or `b` > 9.

## Operation
- Reset values: `ready`=1, `busy`=0, `done`=0, `result`=0, `neg`=0, `invalid`=0, state IDLE, digit index 0, carry register 0.
- IDLE: on `start`=1, latch `a`, `b`, `mode`; set carry register to 1; set index to 0; clear `neg`/`invalid`; compute `invalid` from the latched digits when `mode`=1; go to SUB.
- SUB: each cycle, process digit[index]:
  - Binary: s = a_d + (~b_d & 0xF) + c; digit = s[3:0]; c' = s[4].
  - Decimal: s = a_d + (9 − b_d) + c (range 0..19); s ≥ 10 gives digit = s − 10, c' = 1; otherwise digit = s, c' = 0.
  - Write the digit into `result[index]`, update the carry, and increment the index.
  - After digit DIGITS−1: `neg` = ~c'. Go to DONE, or go to FIX when the macro is enabled and `neg`=1.
- FIX (macro only): recomplement to magnitude. Run the same cell with a_d = 0, b_d = result digit, carry starting at 1, for DIGITS cycles, overwriting `result`. `neg` stays 1. Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored and has no side effects.
- `invalid` does not abort the operation. The result is computed but its value is undefined.
- Equal operands give `result`=0 and `neg`=0.
- `rst` in any state returns all registers to reset values on that edge. No partial result is retained.
- `result`, `neg` and `invalid` are registered. No combinational path from inputs to outputs.

## Timing
- Accept edge E0 is the edge where `start`·`ready` is high.
- SUB occupies the DIGITS cycles after E0. `done` is high in cycle DIGITS+1 after E0, i.e. latency DIGITS+1 cycles.
- With the macro and `neg`=1, FIX adds DIGITS cycles, giving latency 2·DIGITS+1.
- `ready` returns high in the cycle after `done`. The earliest next accept is one cycle after `done`, so back-to-back throughput is one operation per DIGITS+2 cycles.
- `result`, `neg` and `invalid` are stable and valid whenever `done`=1 and until the next accept edge.

## Configuration
- `DIGIT_SUB_RECOMP_EN`:
  - Defined: the FIX state exists. A negative difference is returned as a magnitude in the selected radix, with `neg`=1.
  - Undefined: FIX is absent. A negative difference is returned in 10's/2's complement form, with `neg`=1.

## Structure
- Package `digit_sub_pkg` holds:
  - `DIGIT_W` = 4
  - state enum IDLE/SUB/FIX/DONE (FIX is always encoded, but is unreachable without the macro)
  - `MODE_BIN` = 0, `MODE_DEC` = 1
- Sub-module `digit_sub_cell` is purely combinational and instantiated once.
  - Inputs: a_d[3:0], b_d[3:0], cin, mode.
  - Outputs: d[3:0], cout.
  - It computes the complement of b_d internally and is shared between SUB and FIX.

## Test plan
- Decimal, DIGITS=4: A=0x0042, B=0x0017 → `result`=0x0025, `neg`=0, `done` 5 cycles after accept.
- Decimal: A=0x0017, B=0x0042 → macro on: 0x0025, `neg`=1, latency 9 cycles; macro off: 0x9975, `neg`=1, latency 5 cycles.
- Binary: A=0x0005, B=0x0009 → macro on: 0x0004, `neg`=1; macro off: 0xFFFC, `neg`=1. Also A=0x1234, B=0x1234 → 0x0000, `neg`=0.
- Decimal: A=0x00A0, B=0x0001 → `invalid`=1, `done` still pulses at 5 cycles. Binary with the same operands → `invalid`=0, `result`=0x009F.
- `start` pulsed during SUB with new operands → ignored, first result unchanged. Then `rst` asserted mid-SUB → next cycle `ready`=1, `result`=0, `done` never pulses for the aborted operation.
